// File: rtl/duck_flock_if.sv
// Spawn request and shot handshake between the game logic and the duck flock controller.
interface duck_flock_if;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [9:0]  spawn_x;
  logic        spawn_dir;
  logic [4:0]  spawn_vspd;
  logic        shot_valid;
  logic [10:0] shot_x;
  logic [10:0] shot_y;
  logic        hit;

  modport master (
    output spawn_valid, spawn_x, spawn_dir, spawn_vspd,
    output shot_valid, shot_x, shot_y,
    input  spawn_ready, hit
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_dir, spawn_vspd,
    input  shot_valid, shot_x, shot_y,
    output spawn_ready, hit
  );
endinterface

// File: rtl/duck_flock_ctl.sv
// Duck flock controller: per-channel flight FSMs with bouncing, escape, shot
// detection and falling, plus saturating score and escape counters.
module duck_flock_ctl #(
  parameter int unsigned NUM_DUCKS  = 2,
  parameter int unsigned SCREEN_W   = 1024,
  parameter int unsigned SKY_BOTTOM = 600,
  parameter int unsigned DUCK_W     = 64,
  parameter int unsigned DUCK_H     = 64,
  parameter int unsigned H_SPEED    = 10,
  parameter int unsigned FALL_SPEED = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_frame,
  input  logic [4:0]               reflections,
  duck_flock_if.slave              bus,
  output logic [NUM_DUCKS-1:0]     duck_show,
  output logic [NUM_DUCKS*11-1:0]  duck_x,
  output logic [NUM_DUCKS*11-1:0]  duck_y,
  output logic [7:0]               score,
  output logic [7:0]               escapes
);

  localparam int unsigned PW = 11;
  localparam int unsigned AW = 12;
  localparam int unsigned HW = 13;

  localparam logic [PW-1:0]        X_LIM   = PW'(SCREEN_W - DUCK_W);
  localparam logic [PW-1:0]        Y_LIM   = PW'(SKY_BOTTOM - DUCK_H);
  localparam logic signed [AW-1:0] X_MAX_S = AW'(SCREEN_W - DUCK_W);
  localparam logic signed [AW-1:0] Y_MAX_S = AW'(SKY_BOTTOM - DUCK_H);
  localparam logic signed [AW-1:0] H_STEP  = AW'(H_SPEED);
  localparam logic signed [AW-1:0] F_STEP  = AW'(FALL_SPEED);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_FALL, S_ESCAPE} state_t;

  state_t          state_q  [NUM_DUCKS];
  state_t          state_d  [NUM_DUCKS];
  logic [PW-1:0]   x_q      [NUM_DUCKS];
  logic [PW-1:0]   x_d      [NUM_DUCKS];
  logic [PW-1:0]   y_q      [NUM_DUCKS];
  logic [PW-1:0]   y_d      [NUM_DUCKS];
  logic            hdir_q   [NUM_DUCKS];
  logic            hdir_d   [NUM_DUCKS];
  logic            vdir_q   [NUM_DUCKS];
  logic            vdir_d   [NUM_DUCKS];
  logic [4:0]      vspd_q   [NUM_DUCKS];
  logic [4:0]      vspd_d   [NUM_DUCKS];
  logic [4:0]      bounce_q [NUM_DUCKS];
  logic [4:0]      bounce_d [NUM_DUCKS];

  logic            hit_q, hit_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      escapes_q, escapes_d;

  logic signed [AW-1:0] hx_step [NUM_DUCKS];
  logic signed [AW-1:0] vy_step [NUM_DUCKS];
  logic signed [AW-1:0] esc_y   [NUM_DUCKS];
  logic signed [AW-1:0] fall_y  [NUM_DUCKS];
  logic                 hx_hit  [NUM_DUCKS];
  logic                 vy_hit  [NUM_DUCKS];
  logic [4:0]           bounce_nx [NUM_DUCKS];
  logic [5:0]           bnc_sum [NUM_DUCKS];
  logic [NUM_DUCKS-1:0] in_box;
  logic [NUM_DUCKS-1:0] idle_vec;

  logic                 spawn_done;
  logic                 shot_done;
  logic [3:0]           esc_cnt;
  logic [8:0]           esc_sum;

  // Candidate positions for one frame step; vdir = 1 means moving up (y decreasing).
  always_comb begin : motion_calc
    for (int i = 0; i < int'(NUM_DUCKS); i++) begin
      hx_step[i] = hdir_q[i] ? ($signed({1'b0, x_q[i]}) + H_STEP)
                             : ($signed({1'b0, x_q[i]}) - H_STEP);
      vy_step[i] = vdir_q[i] ? ($signed({1'b0, y_q[i]}) - $signed({7'b0, vspd_q[i]}))
                             : ($signed({1'b0, y_q[i]}) + $signed({7'b0, vspd_q[i]}));
      esc_y[i]   = $signed({1'b0, y_q[i]})
                   - ((vspd_q[i] == 5'd0) ? 12'sd1 : $signed({7'b0, vspd_q[i]}));
      fall_y[i]  = $signed({1'b0, y_q[i]}) + F_STEP;
      hx_hit[i]  = hdir_q[i] ? (hx_step[i] >= X_MAX_S) : (hx_step[i] <= 12'sd0);
      vy_hit[i]  = vdir_q[i] ? (vy_step[i] <= 12'sd0) : (vy_step[i] >= Y_MAX_S);
      bnc_sum[i] = {1'b0, bounce_q[i]} + 6'(hx_hit[i]) + 6'(vy_hit[i]);
      bounce_nx[i] = bnc_sum[i][5] ? 5'h1F : bnc_sum[i][4:0];
      in_box[i]  = (state_q[i] == S_FLY)
                   && ({2'b0, bus.shot_x} >= {2'b0, x_q[i]})
                   && ({2'b0, bus.shot_x} <  ({2'b0, x_q[i]} + HW'(DUCK_W)))
                   && ({2'b0, bus.shot_y} >= {2'b0, y_q[i]})
                   && ({2'b0, bus.shot_y} <  ({2'b0, y_q[i]} + HW'(DUCK_H)));
    end
  end

  // Next-state: spawn to lowest idle channel, shot to lowest hit channel, then motion.
  always_comb begin : next_state
    spawn_done = 1'b0;
    shot_done  = 1'b0;
    esc_cnt    = 4'd0;
    for (int i = 0; i < int'(NUM_DUCKS); i++) begin
      state_d[i]  = state_q[i];
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      hdir_d[i]   = hdir_q[i];
      vdir_d[i]   = vdir_q[i];
      vspd_d[i]   = vspd_q[i];
      bounce_d[i] = bounce_q[i];

      case (state_q[i])
        S_IDLE: begin
          if (bus.spawn_valid && !spawn_done) begin
            spawn_done  = 1'b1;
            state_d[i]  = S_FLY;
            x_d[i]      = ({1'b0, bus.spawn_x} > X_LIM) ? X_LIM : {1'b0, bus.spawn_x};
            y_d[i]      = Y_LIM;
            hdir_d[i]   = bus.spawn_dir;
            vdir_d[i]   = 1'b1;
            vspd_d[i]   = bus.spawn_vspd;
            bounce_d[i] = 5'd0;
          end
        end
        S_FLY: begin
          if (bus.shot_valid && in_box[i] && !shot_done) begin
            shot_done  = 1'b1;
            state_d[i] = S_FALL;
          end else if ((reflections != 5'd0) && (bounce_q[i] >= reflections)) begin
            state_d[i] = S_ESCAPE;
          end else if (new_frame) begin
            x_d[i]      = hx_hit[i] ? (hdir_q[i] ? X_LIM : PW'(0)) : hx_step[i][PW-1:0];
            y_d[i]      = vy_hit[i] ? (vdir_q[i] ? PW'(0) : Y_LIM) : vy_step[i][PW-1:0];
            hdir_d[i]   = hdir_q[i] ^ hx_hit[i];
            vdir_d[i]   = vdir_q[i] ^ vy_hit[i];
            bounce_d[i] = bounce_nx[i];
          end
        end
        S_FALL: begin
          if (new_frame) begin
            if (fall_y[i] >= Y_MAX_S) begin
              state_d[i] = S_IDLE;
              y_d[i]     = Y_LIM;
            end else begin
              y_d[i]     = fall_y[i][PW-1:0];
            end
          end
        end
        S_ESCAPE: begin
          if (new_frame) begin
            if (esc_y[i] < 12'sd0) begin
              state_d[i] = S_IDLE;
              esc_cnt    = esc_cnt + 4'd1;
            end else begin
              y_d[i]     = esc_y[i][PW-1:0];
            end
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end

    hit_d     = shot_done;
    score_d   = (shot_done && (score_q != 8'hFF)) ? (score_q + 8'd1) : score_q;
    esc_sum   = {1'b0, escapes_q} + 9'(esc_cnt);
    escapes_d = esc_sum[8] ? 8'hFF : esc_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_DUCKS); i++) begin
        state_q[i]  <= S_IDLE;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
        hdir_q[i]   <= 1'b0;
        vdir_q[i]   <= 1'b0;
        vspd_q[i]   <= '0;
        bounce_q[i] <= '0;
      end
      hit_q     <= 1'b0;
      score_q   <= '0;
      escapes_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_DUCKS); i++) begin
        state_q[i]  <= state_d[i];
        x_q[i]      <= x_d[i];
        y_q[i]      <= y_d[i];
        hdir_q[i]   <= hdir_d[i];
        vdir_q[i]   <= vdir_d[i];
        vspd_q[i]   <= vspd_d[i];
        bounce_q[i] <= bounce_d[i];
      end
      hit_q     <= hit_d;
      score_q   <= score_d;
      escapes_q <= escapes_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_DUCKS); g++) begin : g_out
    assign idle_vec[g]         = (state_q[g] == S_IDLE);
    assign duck_show[g]        = (state_q[g] != S_IDLE);
    assign duck_x[g*11 +: 11]  = x_q[g];
    assign duck_y[g*11 +: 11]  = y_q[g];
  end

  assign bus.spawn_ready = |idle_vec;
  assign bus.hit         = hit_q;
  assign score           = score_q;
  assign escapes         = escapes_q;

endmodule

// File: doc/duck_flock_ctl.md
DUCK_FLOCK_CTL -- requirements
Module: duck_flock_ctl

Interface
REQ-001 SHALL have parameter NUM_DUCKS, default 2, number of independent duck channels (1..8).
REQ-002 SHALL have parameter SCREEN_W, default 1024, playfield width in pixels.
REQ-003 SHALL have parameter SKY_BOTTOM, default 600, lowest y of the duck top edge plus DUCK_H (grass line).
REQ-004 SHALL have parameter DUCK_W / DUCK_H, default 64 / 64, hit-box size in pixels.
REQ-005 SHALL have parameter H_SPEED, default 10, and FALL_SPEED, default 8, pixels per frame.
REQ-006 SHALL have ports: clk in 1 system clock (65 MHz); rst in 1 reset.
REQ-007 SHALL apply reset asynchronously, active-low, on a single clock (clk).
REQ-008 SHALL have ports: new_frame in 1 one-cycle frame strobe; reflections in 5 bounce limit before escape.
REQ-009 SHALL have ports: spawn_valid in 1; spawn_ready out 1; spawn_x in 10; spawn_dir in 1 (1 = right); spawn_vspd in 5.
REQ-010 SHALL have ports: shot_valid in 1; shot_x in 11; shot_y in 11; hit out 1 one-cycle strobe.
REQ-011 SHALL have ports: duck_show out NUM_DUCKS; duck_x out NUM_DUCKS*11; duck_y out NUM_DUCKS*11 (channel i at bits [11i+10:11i]).
REQ-012 SHALL have ports: score out 8; escapes out 8.

Function
REQ-013 SHALL hold per channel a state machine IDLE, FLY, FALL, ESCAPE, plus x, y (11 b), hdir, vdir, vspd (5 b), bounce count (5 b).
REQ-014 SHALL drive spawn_ready combinationally high when any channel is IDLE.
REQ-015 SHALL, on spawn_valid && spawn_ready, load the lowest-index IDLE channel next cycle: FLY, x = min(spawn_x, SCREEN_W-DUCK_W), y = SKY_BOTTOM-DUCK_H, hdir = spawn_dir, vdir = up, vspd = spawn_vspd, bounce = 0.
REQ-016 SHALL in FLY, on new_frame, step x by H_SPEED in hdir; on reaching/crossing 0 or SCREEN_W-DUCK_W clamp to that edge, invert hdir, increment bounce.
REQ-017 SHALL in FLY, on new_frame, step y by vspd in vdir; on reaching/crossing 0 or SKY_BOTTOM-DUCK_H clamp, invert vdir, increment bounce; simultaneous h and v bounce counts 2.
REQ-018 SHALL move FLY to ESCAPE when bounce >= reflections and reflections != 0; reflections = 0 disables escape.
REQ-019 SHALL in ESCAPE, on new_frame, decrease y by max(vspd,1), x frozen; when y would go below 0 enter IDLE and increment escapes (saturating at 255).
REQ-020 SHALL in FALL, on new_frame, increase y by FALL_SPEED; when y reaches/crosses SKY_BOTTOM-DUCK_H enter IDLE.
REQ-021 SHALL on shot_valid test every FLY channel: hit if x <= shot_x < x+DUCK_W and y <= shot_y < y+DUCK_H, using current registered x, y.
REQ-022 SHALL award a shot to the lowest-index hitting channel only: it enters FALL, hit pulses one cycle later, score increments (saturating at 255).
REQ-023 SHALL give a shot priority over motion for the hit channel when shot_valid and new_frame coincide; other channels move normally.
REQ-024 SHALL not count a channel being spawned in the same cycle as hittable; FALL, ESCAPE, IDLE channels are never hittable.
REQ-025 SHALL drive duck_show high in FLY, FALL, ESCAPE and low in IDLE; duck_x/duck_y are registered state values.
REQ-026 SHALL perform all position arithmetic in 12 b signed to detect underflow before clamping.

Reset
REQ-027 SHALL, while rst low, force all channels IDLE, x = y = 0, bounce = 0, hit = 0, score = 0, escapes = 0, duck_show = 0.
REQ-028 SHALL abandon any in-progress flight on reset mid-operation without incrementing score or escapes.
REQ-029 SHALL ignore spawn_valid, shot_valid and new_frame in the cycle rst deasserts is not required; first accepted event is the cycle after deassertion.

Verification
REQ-030 Spawn x=100, dir=1, vspd=4; 3 frames -> duck0 x=130, y=524, duck_show[0]=1.
REQ-031 Spawn x=1000 (clamped 960), dir=1, reflections=1; 1 frame -> x=960, hdir=left, next cycle ESCAPE; y to <0 -> IDLE, escapes=1.
REQ-032 Two ducks overlapping at (200,300); shot (210,310) -> only duck0 FALL, hit one pulse, score=1; duck1 stays FLY.
REQ-033 Shot and new_frame same cycle at duck box edge (x+63) -> hit registered, duck does not move that frame.
REQ-034 NUM_DUCKS=2 both FLY -> spawn_ready=0, spawn_valid ignored; one duck lands after FALL -> spawn_ready=1.
REQ-035 Score at 255, further hit -> score stays 255; rst low mid-FALL -> all outputs zero immediately.
